// File: rtl/r200_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// r200_mem_arb_pkg
// Shared types for the r200 unified-memory arbiter:
//   arb_state_e  - 3-bit arbiter FSM state encoding
//   arb_owner_e  - which requester owns the bus transaction
//   STARVE_W     - width of the IF starvation counter (holds 0..15)
// Helper:
//   xfer_state() - maps a transaction owner to its XFER state
// -----------------------------------------------------------------------------
package r200_mem_arb_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE     = 3'd0,
        ARB_XFER_IF  = 3'd1,
        ARB_XFER_MEM = 3'd2,
        ARB_RESP_IF  = 3'd3,
        ARB_RESP_MEM = 3'd4
    } arb_state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } arb_owner_e;

    // Wide enough for the largest legal STARVE_MAX (15).
    localparam int STARVE_W = 4;

    function automatic arb_state_e xfer_state(input arb_owner_e owner);
        return (owner == OWN_MEM) ? ARB_XFER_MEM : ARB_XFER_IF;
    endfunction

endpackage

// File: rtl/r200_arb_prio.sv
// -----------------------------------------------------------------------------
// r200_arb_prio
// Winner select for the r200 memory arbiter. MEM has priority over IF, except
// that once MEM has won STARVE_MAX times in a row while IF was waiting, IF is
// forced to win the next collision.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   idle       in   arbiter FSM is in IDLE; grants are only issued then
//   if_req     in   IF request
//   mem_req    in   MEM request
//   if_gnt     out  IF wins this cycle (combinational)
//   mem_gnt    out  MEM wins this cycle (combinational)
//   starve_cnt out  consecutive MEM wins while IF waited (saturating)
// -----------------------------------------------------------------------------
module r200_arb_prio
    import r200_mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                idle,
    input  logic                if_req,
    input  logic                mem_req,
    output logic                if_gnt,
    output logic                mem_gnt,
    output logic [STARVE_W-1:0] starve_cnt
);

    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

    logic if_starved;

    // IF is only "starved" when it is actually competing for the bus.
    assign if_starved = if_req && (starve_cnt == STARVE_LIMIT);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned; a missing assignment would infer a latch.
        if_gnt  = 1'b0;
        mem_gnt = 1'b0;
        if (idle) begin
            if (mem_req && !if_starved) begin
                mem_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (if_gnt) begin
            starve_cnt <= '0;
        end else if (mem_gnt && if_req && (starve_cnt != STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

endmodule

// File: rtl/r200_mem_arb.sv
// -----------------------------------------------------------------------------
// r200_mem_arb
// Arbitrates one single-ported memory bus between instruction fetch (IF) and
// the data-memory stage (MEM). The winning request is registered onto the bus,
// held until bus_ack, and the result is returned to the owner with a one-cycle
// rvalid pulse in the following RESP cycle.
//
// Timeline for one transaction: gnt at cycle 0, bus_req from cycle 1, bus_ack
// at cycle k>=1, rvalid at k+1, next gnt possible at k+2.
//
// Configuration macro:
//   R200_MEMARB_PERF_EN - adds perf_if_wait / perf_mem_wait wait-cycle
//                         counters (increment on req && !gnt, wrap at 2^32).
//
// Ports:
//   clk, rst                       clock / async active-high reset
//   if_req, if_addr                IF read request, held until if_gnt
//   if_gnt, if_rvalid, if_rdata    IF accept / one-cycle data valid / data
//   mem_req, mem_we, mem_addr,
//   mem_wdata                      MEM request, held until mem_gnt
//   mem_gnt, mem_rvalid, mem_rdata MEM accept / completion pulse / read data
//                                  (mem_rdata is 0 for a write completion)
//   bus_req, bus_we, bus_addr,
//   bus_wdata                      registered bus transaction, held to ack
//   bus_ack, bus_rdata             one-cycle completion and read data
//   perf_if_wait, perf_mem_wait    (perf build only) wait-cycle counters
// -----------------------------------------------------------------------------
module r200_mem_arb
    import r200_mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,

    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic          mem_gnt,
    output logic          mem_rvalid,
    output logic [DW-1:0] mem_rdata,

    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_ack,
    input  logic [DW-1:0] bus_rdata
`ifdef R200_MEMARB_PERF_EN
    ,
    output logic [31:0]   perf_if_wait,
    output logic [31:0]   perf_mem_wait
`endif
);

    arb_state_e          state_q;
    arb_state_e          state_d;
    logic                idle;
    logic [STARVE_W-1:0] starve_cnt;

    assign idle = (state_q == ARB_IDLE);

    // -------------------------------------------------------------------------
    // Winner select and starvation tracking
    // -------------------------------------------------------------------------
    r200_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk        (clk),
        .rst        (rst),
        .idle       (idle),
        .if_req     (if_req),
        .mem_req    (mem_req),
        .if_gnt     (if_gnt),
        .mem_gnt    (mem_gnt),
        .starve_cnt (starve_cnt)
    );

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and state-decoded outputs. bus_req and the rvalid
    // pulses come straight from the state register, so an asynchronous reset
    // drops them in the same instant it forces IDLE.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        bus_req    = 1'b0;
        if_rvalid  = 1'b0;
        mem_rvalid = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (mem_gnt) begin
                    state_d = xfer_state(OWN_MEM);
                end else if (if_gnt) begin
                    state_d = xfer_state(OWN_IF);
                end
            end
            ARB_XFER_IF: begin
                bus_req = 1'b1;
                if (bus_ack) begin
                    state_d = ARB_RESP_IF;
                end
            end
            ARB_XFER_MEM: begin
                bus_req = 1'b1;
                if (bus_ack) begin
                    state_d = ARB_RESP_MEM;
                end
            end
            ARB_RESP_IF: begin
                if_rvalid = 1'b1;
                state_d   = ARB_IDLE;
            end
            ARB_RESP_MEM: begin
                mem_rvalid = 1'b1;
                state_d    = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Bus request fields: latched on grant, stable for the whole transfer.
    // An IF fetch is always a read and carries no write data.
    // -------------------------------------------------------------------------
    // NOTE: the datapath registers are reset as well because they are
    // directly visible outputs that must read 0 out of reset; pure storage
    // arrays with no such requirement would be left unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else if (mem_gnt) begin
            bus_we    <= mem_we;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
        end else if (if_gnt) begin
            bus_we    <= 1'b0;
            bus_addr  <= if_addr;
            bus_wdata <= '0;
        end
    end

    // -------------------------------------------------------------------------
    // Response capture. Each port's rdata holds its last captured value; a
    // bus_ack outside XFER is ignored because of the state qualification.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else if (bus_ack) begin
            if (state_q == ARB_XFER_IF) begin
                if_rdata <= bus_rdata;
            end
            if (state_q == ARB_XFER_MEM) begin
                mem_rdata <= bus_we ? '0 : bus_rdata;
            end
        end
    end

`ifdef R200_MEMARB_PERF_EN
    // -------------------------------------------------------------------------
    // Wait-cycle counters: one count per cycle a request is pending but not
    // granted. Natural 32-bit wrap.
    // -------------------------------------------------------------------------
    logic [31:0] perf_if_wait_q;
    logic [31:0] perf_mem_wait_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_if_wait_q  <= '0;
            perf_mem_wait_q <= '0;
        end else begin
            if (if_req && !if_gnt) begin
                perf_if_wait_q <= perf_if_wait_q + 32'd1;
            end
            if (mem_req && !mem_gnt) begin
                perf_mem_wait_q <= perf_mem_wait_q + 32'd1;
            end
        end
    end

    assign perf_if_wait  = perf_if_wait_q;
    assign perf_mem_wait = perf_mem_wait_q;
`endif

endmodule
